// File: rtl/nibble_serial_calculator_if.sv
// Bus bundle for the nibble-serial calculator: operands, op and start handshake in,
// busy/done status, registered result, flag and seven-segment digits out.
interface nibble_serial_calculator_if #(
   parameter int W = 8
);
   localparam int N_DIG = W / 4;

   logic [W-1:0]             i_a;
   logic [W-1:0]             i_b;
   logic [1:0]               i_op;
   logic                     i_start;
   logic                     o_busy;
   logic                     o_done;
   logic [W-1:0]             o_result;
   logic                     o_flag;
   logic [7*(N_DIG+1)-1:0]   o_hex;

   modport master (
      output i_a, i_b, i_op, i_start,
      input  o_busy, o_done, o_result, o_flag, o_hex
   );

   modport slave (
      input  i_a, i_b, i_op, i_start,
      output o_busy, o_done, o_result, o_flag, o_hex
   );
endinterface

// File: rtl/nibble_serial_calculator.sv
// W-bit ADD/SUB/ACC/CLR calculator built on one 4-bit adder slice, iterated LSB nibble
// first, with a registered result and active-low hex digit decode of result and flag.
module nibble_serial_calculator #(
   parameter int W     = 8,
   parameter int N_DIG = W / 4
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   nibble_serial_calculator_if.slave bus
);
   localparam int CW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ACC = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    x_q, x_d;
   logic [W-1:0]    y_q, y_d;
   logic [W-1:0]    shadow_q, shadow_d;
   logic [W-1:0]    result_q, result_d;
   logic [1:0]      op_q, op_d;
   logic            carry_q, carry_d;
   logic            flag_q, flag_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW+1:0]   bitPos;
   logic [4:0]      sum;

   // Result and flag are loaded on the edge entering DONE, so they appear with o_done.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      shadow_d = shadow_q;
      result_d = result_q;
      op_d     = op_q;
      carry_d  = carry_q;
      flag_d   = flag_q;
      cnt_d    = cnt_q;
      bitPos   = {cnt_q, 2'b00};
      sum      = {1'b0, x_q[bitPos +: 4]} + {1'b0, y_q[bitPos +: 4]} + {4'b0000, carry_q};

      case (state_q)
         IDLE: begin
            if (bus.i_start) begin
               case (bus.i_op)
                  OP_CLR: begin
                     result_d = '0;
                     flag_d   = 1'b0;
                     state_d  = DONE;
                  end
                  OP_ADD, OP_SUB, OP_ACC: begin
                     x_d     = (bus.i_op == OP_ACC) ? result_q : bus.i_a;
                     y_d     = (bus.i_op == OP_SUB) ? ~bus.i_b : bus.i_b;
                     op_d    = bus.i_op;
                     carry_d = (bus.i_op == OP_SUB);
                     cnt_d   = '0;
                     state_d = RUN;
                  end
                  default: state_d = IDLE;
               endcase
            end
         end
         RUN: begin
            shadow_d[bitPos +: 4] = sum[3:0];
            carry_d = sum[4];
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(N_DIG - 1)) begin
               result_d = shadow_d;
               flag_d   = (op_q == OP_SUB) ? ~sum[4] : sum[4];
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Synchronous reset discards any in-flight operation.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         shadow_q <= '0;
         result_q <= '0;
         op_q     <= OP_ADD;
         carry_q  <= 1'b0;
         flag_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         shadow_q <= shadow_d;
         result_q <= result_d;
         op_q     <= op_d;
         carry_q  <= carry_d;
         flag_q   <= flag_d;
         cnt_q    <= cnt_d;
      end
   end

   function automatic logic [6:0] hexSeg(input logic [3:0] v);
      case (v)
         4'h0: hexSeg = 7'b1000000;
         4'h1: hexSeg = 7'b1111001;
         4'h2: hexSeg = 7'b0100100;
         4'h3: hexSeg = 7'b0110000;
         4'h4: hexSeg = 7'b0011001;
         4'h5: hexSeg = 7'b0010010;
         4'h6: hexSeg = 7'b0000010;
         4'h7: hexSeg = 7'b1111000;
         4'h8: hexSeg = 7'b0000000;
         4'h9: hexSeg = 7'b0010000;
         4'hA: hexSeg = 7'b0001000;
         4'hB: hexSeg = 7'b0000011;
         4'hC: hexSeg = 7'b1000110;
         4'hD: hexSeg = 7'b0100001;
         4'hE: hexSeg = 7'b0000110;
         default: hexSeg = 7'b0001110;
      endcase
   endfunction

   for (genvar k = 0; k < N_DIG; k++) begin : g_digit
      assign bus.o_hex[7*k +: 7] = hexSeg(result_q[4*k +: 4]);
   end
   assign bus.o_hex[7*N_DIG +: 7] = hexSeg({3'b000, flag_q});

   assign bus.o_busy   = (state_q != IDLE);
   assign bus.o_done   = (state_q == DONE);
   assign bus.o_result = result_q;
   assign bus.o_flag   = flag_q;
endmodule

// File: tb/tb_nibble_serial_calculator.sv
// Directed testbench for nibble_serial_calculator at W=8 and W=16 with hand-computed
// expectations for results, flags, latency, busy/done timing and hex digits.
module tb_nibble_serial_calculator;
   localparam logic [6:0] SEG0 = 7'b1000000;
   localparam logic [6:0] SEG1 = 7'b1111001;
   localparam logic [6:0] SEG2 = 7'b0100100;
   localparam logic [6:0] SEG5 = 7'b0010010;
   localparam logic [6:0] SEG8 = 7'b0000000;
   localparam logic [6:0] SEGE = 7'b0000110;
   localparam logic [6:0] SEGF = 7'b0001110;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   nibble_serial_calculator_if #(.W(8))  bus8 ();
   nibble_serial_calculator_if #(.W(16)) bus16 ();

   nibble_serial_calculator #(.W(8)) dut8 (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus8)
   );

   nibble_serial_calculator #(.W(16)) dut16 (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus16)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one W=8 operation and stop in its done cycle (or after a cycle budget).
   task automatic runOp8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output logic busyAll);
      bus8.i_op    = op;
      bus8.i_a     = a;
      bus8.i_b     = b;
      bus8.i_start = 1'b1;
      nextCycle();
      bus8.i_start = 1'b0;
      bus8.i_a     = 8'hXX;
      bus8.i_b     = 8'hXX;
      lat     = 1;
      busyAll = 1'b1;
      while (bus8.o_done !== 1'b1 && lat < 20) begin
         busyAll &= (bus8.o_busy === 1'b1);
         nextCycle();
         lat++;
      end
      busyAll &= (bus8.o_busy === 1'b1);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus8.i_start = 1'b0;
      bus8.i_op = 2'b00;
      bus8.i_a = 8'h00;
      bus8.i_b = 8'h00;
      bus16.i_start = 1'b0;
      bus16.i_op = 2'b00;
      bus16.i_a = 16'h0000;
      bus16.i_b = 16'h0000;
      nextCycle();
      nextCycle();
      checks++;
      if (bus8.o_result !== 8'h00 || bus8.o_flag !== 1'b0 || bus8.o_busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_state: result=%h flag=%b busy=%b, expected 00/0/0",
                  bus8.o_result, bus8.o_flag, bus8.o_busy);
      end
      checks++;
      if (bus8.o_hex !== {SEG0, SEG0, SEG0}) begin
         errors++;
         $display("[TB] FAIL reset_hex: got %b expected %b", bus8.o_hex, {SEG0, SEG0, SEG0});
      end
      bus8.i_start = 1'b1;
      bus8.i_a = 8'h11;
      bus8.i_b = 8'h22;
      for (int i = 0; i < 2; i++) begin
         nextCycle();
         checks++;
         if (bus8.o_done !== 1'b0 || bus8.o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_with_start: done=%b busy=%b, expected 0/0",
                     bus8.o_done, bus8.o_busy);
         end
      end
      bus8.i_start = 1'b0;
      reset = 1'b0;
      nextCycle();
      checks++;
      if (bus8.o_busy !== 1'b0 || bus8.o_result !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_release: busy=%b result=%h, expected 0/00",
                  bus8.o_busy, bus8.o_result);
      end
   endtask

   task automatic test_add();
      int   lat;
      logic busyAll;
      runOp8(2'b00, 8'h88, 8'h88, lat, busyAll);
      checks++;
      if (lat !== 3 || busyAll !== 1'b1) begin
         errors++;
         $display("[TB] FAIL add_timing: latency=%0d busyAll=%b, expected 3/1", lat, busyAll);
      end
      checks++;
      if (bus8.o_result !== 8'h10 || bus8.o_flag !== 1'b1) begin
         errors++;
         $display("[TB] FAIL add_88_88: result=%h flag=%b, expected 10/1", bus8.o_result, bus8.o_flag);
      end
      checks++;
      if (bus8.o_hex !== {SEG1, SEG1, SEG0}) begin
         errors++;
         $display("[TB] FAIL add_88_88_hex: got %b expected %b", bus8.o_hex, {SEG1, SEG1, SEG0});
      end
      nextCycle();
      checks++;
      if (bus8.o_busy !== 1'b0 || bus8.o_done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL add_after_done: busy=%b done=%b, expected 0/0", bus8.o_busy, bus8.o_done);
      end
      runOp8(2'b00, 8'h23, 8'h35, lat, busyAll);
      checks++;
      if (bus8.o_result !== 8'h58 || bus8.o_flag !== 1'b0 || bus8.o_hex !== {SEG0, SEG5, SEG8}) begin
         errors++;
         $display("[TB] FAIL add_23_35: result=%h flag=%b hex=%b, expected 58/0/%b",
                  bus8.o_result, bus8.o_flag, bus8.o_hex, {SEG0, SEG5, SEG8});
      end
      nextCycle();
   endtask

   task automatic test_sub();
      int   lat;
      logic busyAll;
      runOp8(2'b01, 8'h05, 8'h07, lat, busyAll);
      checks++;
      if (bus8.o_result !== 8'hFE || bus8.o_flag !== 1'b1 || lat !== 3) begin
         errors++;
         $display("[TB] FAIL sub_05_07: result=%h flag=%b latency=%0d, expected FE/1/3",
                  bus8.o_result, bus8.o_flag, lat);
      end
      checks++;
      if (bus8.o_hex !== {SEG1, SEGF, SEGE}) begin
         errors++;
         $display("[TB] FAIL sub_05_07_hex: got %b expected %b", bus8.o_hex, {SEG1, SEGF, SEGE});
      end
      nextCycle();
      runOp8(2'b01, 8'h07, 8'h05, lat, busyAll);
      checks++;
      if (bus8.o_result !== 8'h02 || bus8.o_flag !== 1'b0 || bus8.o_hex !== {SEG0, SEG0, SEG2}) begin
         errors++;
         $display("[TB] FAIL sub_07_05: result=%h flag=%b hex=%b, expected 02/0/%b",
                  bus8.o_result, bus8.o_flag, bus8.o_hex, {SEG0, SEG0, SEG2});
      end
      nextCycle();
   endtask

   task automatic test_acc();
      int   lat;
      logic busyAll;
      runOp8(2'b11, 8'h00, 8'h00, lat, busyAll);
      checks++;
      if (lat !== 1 || busyAll !== 1'b1 || bus8.o_result !== 8'h00 || bus8.o_flag !== 1'b0) begin
         errors++;
         $display("[TB] FAIL clr: latency=%0d busy=%b result=%h flag=%b, expected 1/1/00/0",
                  lat, busyAll, bus8.o_result, bus8.o_flag);
      end
      nextCycle();
      runOp8(2'b10, 8'hA5, 8'hFF, lat, busyAll);
      checks++;
      if (bus8.o_result !== 8'hFF || bus8.o_flag !== 1'b0 || lat !== 3) begin
         errors++;
         $display("[TB] FAIL acc_ff: result=%h flag=%b latency=%0d, expected FF/0/3",
                  bus8.o_result, bus8.o_flag, lat);
      end
      nextCycle();
      runOp8(2'b10, 8'h5A, 8'h01, lat, busyAll);
      checks++;
      if (bus8.o_result !== 8'h00 || bus8.o_flag !== 1'b1 || bus8.o_hex !== {SEG1, SEG0, SEG0}) begin
         errors++;
         $display("[TB] FAIL acc_chain: result=%h flag=%b hex=%b, expected 00/1/%b",
                  bus8.o_result, bus8.o_flag, bus8.o_hex, {SEG1, SEG0, SEG0});
      end
      nextCycle();
   endtask

   task automatic test_back_to_back();
      bus8.i_op    = 2'b00;
      bus8.i_a     = 8'h11;
      bus8.i_b     = 8'h22;
      bus8.i_start = 1'b1;
      nextCycle();
      bus8.i_a = 8'h40;
      bus8.i_b = 8'h40;
      nextCycle();
      nextCycle();
      bus8.i_start = 1'b0;
      checks++;
      if (bus8.o_done !== 1'b1 || bus8.o_result !== 8'h33) begin
         errors++;
         $display("[TB] FAIL start_while_busy: done=%b result=%h, expected 1/33",
                  bus8.o_done, bus8.o_result);
      end
      for (int i = 0; i < 4; i++) begin
         nextCycle();
         checks++;
         if (bus8.o_busy !== 1'b0 || bus8.o_done !== 1'b0 || bus8.o_result !== 8'h33) begin
            errors++;
            $display("[TB] FAIL no_queued_op: busy=%b done=%b result=%h, expected 0/0/33",
                     bus8.o_busy, bus8.o_done, bus8.o_result);
         end
      end
      bus8.i_a     = 8'h12;
      bus8.i_b     = 8'h34;
      bus8.i_start = 1'b1;
      nextCycle();
      bus8.i_start = 1'b0;
      reset = 1'b1;
      nextCycle();
      checks++;
      if (bus8.o_busy !== 1'b0 || bus8.o_done !== 1'b0 || bus8.o_result !== 8'h00 ||
          bus8.o_hex !== {SEG0, SEG0, SEG0}) begin
         errors++;
         $display("[TB] FAIL reset_mid_run: busy=%b done=%b result=%h hex=%b, expected 0/0/00/all-zero digits",
                  bus8.o_busy, bus8.o_done, bus8.o_result, bus8.o_hex);
      end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         nextCycle();
         checks++;
         if (bus8.o_done !== 1'b0 || bus8.o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_discard: done=%b busy=%b, expected 0/0", bus8.o_done, bus8.o_busy);
         end
      end
   endtask

   task automatic test_wide();
      int   lat;
      logic busyAll;
      bus16.i_op    = 2'b00;
      bus16.i_a     = 16'hFFFF;
      bus16.i_b     = 16'h0001;
      bus16.i_start = 1'b1;
      nextCycle();
      bus16.i_start = 1'b0;
      lat     = 1;
      busyAll = 1'b1;
      while (bus16.o_done !== 1'b1 && lat < 20) begin
         busyAll &= (bus16.o_busy === 1'b1);
         nextCycle();
         lat++;
      end
      checks++;
      if (lat !== 5 || busyAll !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wide_timing: latency=%0d busyAll=%b, expected 5/1", lat, busyAll);
      end
      checks++;
      if (bus16.o_result !== 16'h0000 || bus16.o_flag !== 1'b1 ||
          bus16.o_hex !== {SEG1, SEG0, SEG0, SEG0, SEG0}) begin
         errors++;
         $display("[TB] FAIL wide_ffff_0001: result=%h flag=%b hex=%b, expected 0000/1/%b",
                  bus16.o_result, bus16.o_flag, bus16.o_hex, {SEG1, SEG0, SEG0, SEG0, SEG0});
      end
      nextCycle();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_acc();
      test_back_to_back();
      test_wide();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
